// File: rtl/serial2mem.sv
// serial2mem: rebuilds DW-bit records (MSB byte first, trailer TRAIL0,TRAIL1) from a UART byte stream into a FIFO
// Ports: clock (state on falling edge), reset (async, active-high), uart_data/uart_valid (byte strobe, no backpressure),
//   write_data/write_clock_enable (FIFO write), write_full (FIFO full), frame_error/overflow (one-cycle pulses), synced.
// Optional SERIAL2MEM_STATS_EN adds frame_error_count, overflow_count (saturating) and record_count (wrapping).
module serial2mem #(
  parameter int         DW     = 48,
  parameter logic [7:0] TRAIL0 = 8'h0a,
  parameter logic [7:0] TRAIL1 = 8'h0d
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    uart_data,
  input  logic          uart_valid,
  output logic [DW-1:0] write_data,
  output logic          write_clock_enable,
  input  logic          write_full,
  output logic          frame_error,
  output logic          overflow,
  output logic          synced
`ifdef SERIAL2MEM_STATS_EN
  ,
  output logic [7:0]    frame_error_count,
  output logic [7:0]    overflow_count,
  output logic [15:0]   record_count
`endif
);
  localparam int NB = DW / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [1:0] RESYNC = 2'd0, COLLECT = 2'd1, TRAIL_A = 2'd2, TRAIL_B = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          prev_t0;
  logic [DW-1:0] shift;
  logic [DW-1:0] held;
  logic          held_valid;
  logic          is_t0, is_t1, last_byte, drain, complete;
  always_comb begin
    is_t0     = uart_data == TRAIL0;
    is_t1     = uart_data == TRAIL1;
    last_byte = count == CW'(NB - 1);
    drain     = held_valid && !write_full;
    complete  = uart_valid && state == TRAIL_B && is_t1;
    synced    = state != RESYNC;
  end
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state       <= RESYNC;
      count       <= '0;
      prev_t0     <= 1'b0;
      shift       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (uart_valid) begin
        case (state)
          RESYNC: begin
            prev_t0 <= is_t0;
            state   <= prev_t0 && is_t1 ? COLLECT : RESYNC;
            count   <= '0;
          end
          COLLECT: begin
            shift <= (shift << 8) | DW'(uart_data);
            count <= last_byte ? '0 : count + 1'b1;
            state <= last_byte ? TRAIL_A : COLLECT;
          end
          TRAIL_A: begin
            state       <= is_t0 ? TRAIL_B : RESYNC;
            frame_error <= !is_t0;
            prev_t0     <= 1'b0;
          end
          default: begin
            // a TRAIL0 in place of TRAIL1 may itself start the next resync pair
            state       <= is_t1 ? COLLECT : RESYNC;
            frame_error <= !is_t1;
            prev_t0     <= is_t0;
            count       <= '0;
          end
        endcase
      end
    end
  end
  // one-entry holding stage: a draining entry frees the slot on the same edge a new record lands
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      held               <= '0;
      held_valid         <= 1'b0;
      write_data         <= '0;
      write_clock_enable <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      write_clock_enable <= drain;
      overflow           <= complete && held_valid && !drain;
      if (drain) write_data <= held;
      if (complete && (!held_valid || drain)) begin
        held       <= shift;
        held_valid <= 1'b1;
      end else if (drain) begin
        held_valid <= 1'b0;
      end
    end
  end
`ifdef SERIAL2MEM_STATS_EN
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      frame_error_count <= '0;
      overflow_count    <= '0;
      record_count      <= '0;
    end else begin
      frame_error_count <= frame_error_count + {7'd0, frame_error && frame_error_count != 8'hff};
      overflow_count    <= overflow_count + {7'd0, overflow && overflow_count != 8'hff};
      record_count      <= record_count + {15'd0, write_clock_enable};
    end
  end
`endif
endmodule

// File: tb/tb_serial2mem.sv
// tb_serial2mem: table vectors, directed corner sequences and randomized traffic against a byte-level reference model
module tb_serial2mem;
  localparam int DW = 48;
  localparam int NB = DW / 8;
  localparam logic [7:0] T0 = 8'h0a, T1 = 8'h0d;
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    uart_data = 8'h00;
  logic          uart_valid = 1'b0;
  logic          write_full = 1'b0;
  logic [DW-1:0] write_data;
  logic          write_clock_enable, frame_error, overflow, synced;
`ifdef SERIAL2MEM_STATS_EN
  logic [7:0]    frame_error_count, overflow_count;
  logic [15:0]   record_count;
`endif
  always #5 clock = ~clock;
  serial2mem dut (
    .clock(clock),
    .reset(reset),
    .uart_data(uart_data),
    .uart_valid(uart_valid),
    .write_data(write_data),
    .write_clock_enable(write_clock_enable),
    .write_full(write_full),
    .frame_error(frame_error),
    .overflow(overflow),
    .synced(synced)
`ifdef SERIAL2MEM_STATS_EN
    ,
    .frame_error_count(frame_error_count),
    .overflow_count(overflow_count),
    .record_count(record_count)
`endif
  );
  int errors = 0, checks = 0, n_wce = 0, n_fe = 0, n_ovf = 0;
  logic [DW-1:0] wq[$];
  // reference model: byte list of the current frame plus a one-slot holding queue
  bit            m_sync, m_last_t0, m_hv;
  logic [7:0]    m_buf[$];
  logic [DW-1:0] m_held;
  bit            exp_wce, exp_fe, exp_ovf, exp_sync;
  logic [DW-1:0] exp_wdata;
  function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic void model_reset();
    m_sync = 0; m_last_t0 = 0; m_hv = 0; m_held = '0; m_buf.delete();
    exp_wce = 0; exp_fe = 0; exp_ovf = 0; exp_sync = 0; exp_wdata = '0;
  endfunction
  function automatic void model_step(bit v, logic [7:0] d, bit f);
    bit drain = m_hv && !f;
    bit done = 0;
    logic [DW-1:0] rec = '0;
    exp_wce = drain;
    if (drain) exp_wdata = m_held;
    exp_fe = 0;
    exp_ovf = 0;
    if (v) begin
      if (!m_sync) begin
        m_sync = m_last_t0 && d == T1;
        m_last_t0 = d == T0;
        m_buf.delete();
      end else begin
        m_buf.push_back(d);
        if (m_buf.size() == NB + 1 && d != T0) begin
          exp_fe = 1; m_sync = 0; m_last_t0 = 0; m_buf.delete();
        end else if (m_buf.size() == NB + 2) begin
          if (d == T1) begin
            done = 1;
            for (int i = 0; i < NB; i++) rec = (rec << 8) | DW'(m_buf[i]);
          end else begin
            exp_fe = 1; m_sync = 0; m_last_t0 = d == T0;
          end
          m_buf.delete();
        end
      end
    end
    if (done) begin
      if (m_hv && !drain) exp_ovf = 1;
      else begin m_held = rec; m_hv = 1; end
    end else if (drain) m_hv = 0;
    exp_sync = m_sync;
  endfunction
  task automatic cycle(input bit v, input logic [7:0] d, input bit f);
    @(posedge clock);
    chk("write_clock_enable", 64'(write_clock_enable), 64'(exp_wce));
    chk("write_data", 64'(write_data), 64'(exp_wdata));
    chk("frame_error", 64'(frame_error), 64'(exp_fe));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    chk("synced", 64'(synced), 64'(exp_sync));
    if (write_clock_enable) begin wq.push_back(write_data); n_wce++; end
    n_fe += int'(frame_error);
    n_ovf += int'(overflow);
    uart_valid = v; uart_data = d; write_full = f;
    model_step(v, d, f);
  endtask
  task automatic do_reset();
    @(posedge clock);
    #2 reset = 1'b1;
    uart_valid = 1'b0; write_full = 1'b0;
    #1;
    chk("reset write_clock_enable", 64'(write_clock_enable), 64'd0);
    chk("reset write_data", 64'(write_data), 64'd0);
    chk("reset frame_error", 64'(frame_error), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset synced", 64'(synced), 64'd0);
    model_reset();
    @(posedge clock);
    reset = 1'b0;
  endtask
  task automatic send_rec(input logic [DW-1:0] r, input bit f, input bit f_last);
    for (int i = 0; i < NB; i++) cycle(1, r[DW-1-8*i -: 8], f);
    cycle(1, T0, f);
    cycle(1, T1, f_last);
  endtask
  typedef struct { bit v; logic [7:0] d; bit wce; bit fe; bit syn; logic [DW-1:0] wd; } vec_t;
  vec_t tbl[$];
  function automatic void add(bit v, logic [7:0] d, bit wce, bit fe, bit syn, logic [DW-1:0] wd);
    tbl.push_back('{v, d, wce, fe, syn, wd});
  endfunction
  initial begin
    logic [DW-1:0] r1 = 48'h112233445566, r2 = 48'hAABBCCDDEEFF, rr;
    int w0, o0;
    add(1, T0, 0, 0, 0, 0); add(1, T1, 0, 0, 1, 0);
    for (int i = 0; i < NB; i++) add(1, r1[DW-1-8*i -: 8], 0, 0, 1, 0);
    add(1, T0, 0, 0, 1, 0); add(1, T1, 0, 0, 1, 0); add(0, 8'h00, 1, 0, 1, r1);
    for (int i = 0; i < NB; i++) add(1, 8'(i + 1), 0, 0, 1, r1);
    add(1, T0, 0, 0, 1, r1); add(1, 8'h0e, 0, 1, 0, r1);
    add(1, T0, 0, 0, 0, r1); add(1, T1, 0, 0, 1, r1);
    for (int i = 0; i < NB; i++) add(1, r2[DW-1-8*i -: 8], 0, 0, 1, r1);
    add(1, T0, 0, 0, 1, r1); add(1, T1, 0, 0, 1, r1); add(0, 8'h00, 1, 0, 1, r2);
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].d, 0);
      @(negedge clock); #1;
      chk($sformatf("tbl[%0d] wce", i), 64'(write_clock_enable), 64'(tbl[i].wce));
      chk($sformatf("tbl[%0d] fe", i), 64'(frame_error), 64'(tbl[i].fe));
      chk($sformatf("tbl[%0d] synced", i), 64'(synced), 64'(tbl[i].syn));
      chk($sformatf("tbl[%0d] wdata", i), 64'(write_data), 64'(tbl[i].wd));
    end
    // overflow: two records while full, second dropped, first survives
    do_reset();
    cycle(1, T0, 0); cycle(1, T1, 0);
    w0 = n_wce; o0 = n_ovf;
    send_rec(48'h01, 1, 1); send_rec(48'h02, 1, 1);
    cycle(0, 0, 1); cycle(0, 0, 1);
    chk("ovf pulses while full", 64'(n_ovf - o0), 64'd1);
    chk("writes while full", 64'(n_wce - w0), 64'd0);
    repeat (3) cycle(0, 0, 0);
    chk("writes after release", 64'(n_wce - w0), 64'd1);
    chk("released record", 64'(wq[$]), 64'h01);
    // completion on the same edge the held record drains
    w0 = n_wce; o0 = n_ovf;
    send_rec(48'hA0A0, 1, 1);
    send_rec(48'hB0B0, 1, 0);
    repeat (3) cycle(0, 0, 0);
    chk("simultaneous writes", 64'(n_wce - w0), 64'd2);
    chk("simultaneous ovf", 64'(n_ovf - o0), 64'd0);
    chk("simultaneous first", 64'(wq[wq.size()-2]), 64'hA0A0);
    chk("simultaneous second", 64'(wq[$]), 64'hB0B0);
    // reset mid-record, including a held record blocked by full
    send_rec(48'hDEAD, 1, 1);
    cycle(1, 8'h11, 1); cycle(1, 8'h22, 1); cycle(1, 8'h33, 1);
    w0 = n_wce;
    do_reset();
    repeat (3) cycle(0, 0, 0);
    cycle(1, T0, 0); cycle(1, T1, 0);
    send_rec(48'h0C0FFEE00001, 0, 0);
    repeat (3) cycle(0, 0, 0);
    chk("writes after reset", 64'(n_wce - w0), 64'd1);
    chk("record after reset", 64'(wq[$]), 64'h0C0FFEE00001);
    // randomized traffic, every cycle checked against the model
    for (int k = 0; k < 400; k++) begin
      int kind = int'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) cycle(0, 8'($urandom), $urandom_range(0, 3) == 0);
      if (kind == 0) cycle(1, 8'($urandom), $urandom_range(0, 3) == 0);
      else if (kind <= 2) begin cycle(1, T0, 0); cycle(1, T1, $urandom_range(0, 3) == 0); end
      else begin
        rr = {$urandom, $urandom};
        for (int i = 0; i < NB; i++) cycle(1, rr[DW-1-8*i -: 8], $urandom_range(0, 3) == 0);
        cycle(1, kind == 3 ? 8'($urandom) : T0, $urandom_range(0, 3) == 0);
        cycle(1, kind == 4 ? T0 : T1, $urandom_range(0, 3) == 0);
        if (kind == 4 && $urandom_range(0, 1) == 1) cycle(1, T1, 0);
      end
    end
    repeat (3) cycle(0, 0, 0);
`ifdef SERIAL2MEM_STATS_EN
    do_reset();
    repeat (300) begin
      cycle(1, T0, 0); cycle(1, T1, 0);
      for (int i = 0; i < NB; i++) cycle(1, 8'(i), 0);
      cycle(1, T0, 0); cycle(1, 8'h0e, 0);
    end
    repeat (2) cycle(0, 0, 0);
    chk("frame_error_count", 64'(frame_error_count), 64'hff);
    cycle(1, T0, 0); cycle(1, T1, 0);
    for (int j = 0; j < 5; j++) begin send_rec(DW'(j), 0, 0); cycle(0, 0, 0); end
    repeat (3) cycle(0, 0, 0);
    chk("record_count", 64'(record_count), 64'd5);
    chk("overflow_count", 64'(overflow_count), 64'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
